// File: rtl/lsu_ctrl.sv
// lsu_ctrl: MIPS load/store unit onto a word-wide memory; sub-word stores by read-modify-write.
// Optional build macro MEM_PROTECT_EN rejects stores below 32'h0040_0000.
`default_nettype none

module lsu_ctrl #(
    parameter int BIG_ENDIAN = 1
) (
    input  logic        i_CLK,
    input  logic        i_RSTn,
    input  logic        i_req,
    input  logic        i_store,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_busy,
    output logic [31:0] o_mem_a,
    output logic [31:0] o_mem_wd,
    output logic        o_mem_we,
    input  logic [31:0] i_mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rbuf_q, rbuf_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_illegal, req_misalign, req_protect, req_bad;
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext, st_merge;

    always_comb begin
        req_illegal  = i_store ? (i_op[2] || (i_op[1:0] == 2'b11))
                               : ((i_op == 3'b011) || (i_op == 3'b110) || (i_op == 3'b111));
        req_misalign = ((i_op[1:0] == 2'b01) && i_addr[0]) ||
                       ((i_op == 3'b010) && (i_addr[1:0] != 2'b00));
`ifdef MEM_PROTECT_EN
        req_protect  = i_store && (i_addr < 32'h0040_0000);
`else
        req_protect  = 1'b0;
`endif
        req_bad      = req_illegal || req_misalign || req_protect;
    end

    // Bit offset of the addressed byte/half within the word, per lane ordering.
    always_comb begin
        if (BIG_ENDIAN != 0) begin
            byte_sh = {(2'd3 - addr_q[1:0]), 3'b000};
            half_sh = addr_q[1] ? 5'd0 : 5'd16;
        end else begin
            byte_sh = {addr_q[1:0], 3'b000};
            half_sh = addr_q[1] ? 5'd16 : 5'd0;
        end
    end

    always_comb begin
        ld_byte = 8'(i_mem_rd >> byte_sh);
        ld_half = 16'(i_mem_rd >> half_sh);
        case (op_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = i_mem_rd;
        endcase
    end

    always_comb begin
        case (op_q)
            3'b000:  st_merge = (rbuf_q & ~(32'h0000_00FF << byte_sh)) |
                                ({24'd0, wdata_q[7:0]} << byte_sh);
            3'b001:  st_merge = (rbuf_q & ~(32'h0000_FFFF << half_sh)) |
                                ({16'd0, wdata_q[15:0]} << half_sh);
            default: st_merge = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        store_d = store_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rbuf_d  = rbuf_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (i_req) begin
                    err_d = req_bad;
                    // Rejected requests leave the datapath registers untouched.
                    if (req_bad) begin
                        state_d = DONE;
                    end else begin
                        store_d = i_store;
                        op_d    = i_op;
                        addr_d  = i_addr;
                        wdata_d = i_wdata;
                        state_d = (i_store && (i_op == 3'b010)) ? WR : RD;
                    end
                end
            end
            RD: begin
                rbuf_d = i_mem_rd;
                if (store_q) begin
                    state_d = WR;
                end else begin
                    rdata_d = ld_ext;
                    state_d = DONE;
                end
            end
            WR:      state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RSTn) begin
            state_q <= IDLE;
            store_q <= 1'b0;
            op_q    <= 3'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            rbuf_q  <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rbuf_q  <= rbuf_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign o_rdata  = rdata_q;
    assign o_ack    = (state_q == DONE);
    assign o_err    = (state_q == DONE) && err_q;
    assign o_busy   = (state_q != IDLE);
    assign o_mem_a  = {addr_q[31:2], 2'b00};
    assign o_mem_wd = st_merge;
    assign o_mem_we = (state_q == WR) && i_RSTn;

endmodule

`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and randomized checks of lsu_ctrl against a byte-level reference model.
`default_nettype none

module tb_lsu_ctrl;
    localparam int BE = 1;

    logic        clk = 1'b0;
    logic        rstn, req, store;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        ack, err, busy, mem_we;

    bit   [31:0] mem     [256];
    bit   [31:0] ref_mem [256];
    logic [31:0] ref_rdata;
    int          n_chk  = 0;
    int          n_pass = 0;

    lsu_ctrl #(.BIG_ENDIAN(BE)) dut (
        .i_CLK(clk), .i_RSTn(rstn), .i_req(req), .i_store(store), .i_op(op),
        .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_ack(ack), .o_err(err),
        .o_busy(busy), .o_mem_a(mem_a), .o_mem_wd(mem_wd), .o_mem_we(mem_we),
        .i_mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    assign mem_rd = mem[mem_a[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[9:2]] <= mem_wd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Byte k of a word, with byte 0 being the lowest address.
    function automatic logic [7:0] get_b(input logic [31:0] w, input int k);
        return (BE != 0) ? w[8*(3-k) +: 8] : w[8*k +: 8];
    endfunction

    function automatic logic [31:0] set_b(input logic [31:0] w, input int k, input logic [7:0] v);
        logic [31:0] r = w;
        if (BE != 0) r[8*(3-k) +: 8] = v;
        else         r[8*k +: 8] = v;
        return r;
    endfunction

    task automatic do_req(input logic st, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] d);
        int          k = int'(a[1:0]);
        int          idx = int'(a[9:2]);
        logic [31:0] w = ref_mem[idx];
        logic [15:0] h;
        logic        bad;
        int          lat_e, lat, wes;
        logic        seen, errv;
        logic [31:0] rdv;

        if (st) bad = !(o == 3'd0 || o == 3'd1 || o == 3'd2);
        else    bad = !(o == 3'd0 || o == 3'd1 || o == 3'd2 || o == 3'd4 || o == 3'd5);
        if ((o == 3'd1 || o == 3'd5) && a[0]) bad = 1'b1;
        if (o == 3'd2 && a[1:0] != 2'b00) bad = 1'b1;
`ifdef MEM_PROTECT_EN
        if (st && a < 32'h0040_0000) bad = 1'b1;
`endif
        if (bad)                 lat_e = 1;
        else if (!st || o == 3'd2) lat_e = 2;
        else                     lat_e = 3;

        if (!bad && !st) begin
            h = (BE != 0) ? {get_b(w, k), get_b(w, k + 1)} : {get_b(w, k + 1), get_b(w, k)};
            case (o)
                3'd0: ref_rdata = 32'(signed'(get_b(w, k)));
                3'd4: ref_rdata = {24'd0, get_b(w, k)};
                3'd1: ref_rdata = 32'(signed'(h));
                3'd5: ref_rdata = {16'd0, h};
                default: ref_rdata = w;
            endcase
        end
        if (!bad && st) begin
            if (o == 3'd2) w = d;
            else if (o == 3'd0) w = set_b(w, k, d[7:0]);
            else if (BE != 0) w = set_b(set_b(w, k, d[15:8]), k + 1, d[7:0]);
            else w = set_b(set_b(w, k, d[7:0]), k + 1, d[15:8]);
            ref_mem[idx] = w;
        end

        @(negedge clk);
        req = 1'b1; store = st; op = o; addr = a; wdata = d;
        @(posedge clk);
        lat = 0; wes = 0; seen = 1'b0; errv = 1'b0; rdv = 32'd0;
        for (int c = 1; c <= 8 && !seen; c++) begin
            @(negedge clk);
            req = 1'b0;
            if (c == 1) check("busy", 32'(busy), 32'd1);
            if (mem_we) wes++;
            if (ack) begin seen = 1'b1; lat = c; errv = err; rdv = rdata; end
        end
        check("latency", lat, lat_e);
        check("err", 32'(errv), 32'(bad));
        check("rdata", rdv, ref_rdata);
        check("we_cycles", wes, (!bad && st) ? 1 : 0);
        @(negedge clk);
        check("ack_pulse", {30'd0, ack, busy}, 32'd0);
        check("mem_word", mem[idx], ref_mem[idx]);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {27'd0, ack, err, busy, mem_we, 1'b0}, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_mem_a"}, mem_a, 32'd0);
        check({tag, "_mem_wd"}, mem_wd, 32'd0);
    endtask

    task automatic reset_during_sb(input logic [31:0] a);
        int idx = int'(a[9:2]);
        @(negedge clk);
        req = 1'b1; store = 1'b1; op = 3'd0; addr = a; wdata = 32'h0000_00E7;
        @(posedge clk);
        @(negedge clk); req = 1'b0;
        @(negedge clk);
        check("rst_in_wr", 32'(mem_we), 32'd1);
        rstn = 1'b0;
        @(negedge clk);
        check_all_zero("rst_mid");
        check("rst_mem", mem[idx], ref_mem[idx]);
        ref_rdata = 32'd0;
        rstn = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        rstn = 1'b0; req = 1'b0; store = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
        ref_rdata = 32'd0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rstn = 1'b1;

        do_req(1'b1, 3'd2, 32'h7FFF_FF10, 32'h1234_5678);
        do_req(1'b0, 3'd2, 32'h7FFF_FF10, 32'd0);
        check("spec_lw", rdata, 32'h1234_5678);
        do_req(1'b1, 3'd2, 32'h7FFF_FF20, 32'h8899_AABB);
        do_req(1'b0, 3'd0, 32'h7FFF_FF21, 32'd0);
        check("spec_lb", rdata, 32'hFFFF_FF99);
        do_req(1'b0, 3'd4, 32'h7FFF_FF21, 32'd0);
        check("spec_lbu", rdata, 32'h0000_0099);
        do_req(1'b0, 3'd1, 32'h7FFF_FF22, 32'd0);
        check("spec_lh", rdata, 32'hFFFF_AABB);
        do_req(1'b0, 3'd5, 32'h7FFF_FF20, 32'd0);
        check("spec_lhu", rdata, 32'h0000_8899);
        do_req(1'b1, 3'd0, 32'h7FFF_FF22, 32'h0000_0011);
        check("spec_sb", mem[8'hC8], 32'h8899_11BB);
        do_req(1'b1, 3'd1, 32'h7FFF_FF20, 32'h0000_CAFE);
        check("spec_sh", mem[8'hC8], 32'hCAFE_11BB);
        do_req(1'b0, 3'd2, 32'h7FFF_FF12, 32'd0);
        do_req(1'b1, 3'd1, 32'h7FFF_FF11, 32'h0000_BEEF);
        do_req(1'b0, 3'd7, 32'h7FFF_FF10, 32'd0);
        check("spec_err_rdata", rdata, 32'h0000_8899);
        reset_during_sb(32'h7FFF_FF20);
        do_req(1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF);
        do_req(1'b0, 3'd2, 32'h0000_0100, 32'd0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 4) == 0) a = 32'h0000_0100 + 32'($urandom_range(0, 15));
            else                           a = 32'h7FFF_FF00 + 32'($urandom_range(0, 63));
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
